mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto one memory port; grant one cycle after request, done combinational with mem_done.
// No queueing: requesters stall via if_busy/dm_busy until their done; a hung access aborts with err after TIMEOUT cycles.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_busy,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  input  logic              mem_err
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  // Terminal count is hit on the TIMEOUT-th access cycle (counter holds cycles already spent).
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_dm_q;
  logic [15:0]       cnt_q;
  logic              discard_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic if_want, dm_want, grant_if, grant_dm;
  logic in_acc, tmo, finish, if_drop;

  always_comb begin
    if_want  = if_req & ~if_flush;
    dm_want  = dm_rd | dm_wr;
    grant_dm = dm_want & (~if_want | ~last_dm_q);
    grant_if = if_want & ~grant_dm;
    in_acc   = (state_q != IDLE);
    tmo      = in_acc & ~mem_done & (cnt_q == TMO_LAST);
    finish   = in_acc & (mem_done | tmo);
    if_drop  = discard_q | if_flush;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = DM_ACC;
        else if (grant_if) state_d = IF_ACC;
      end
      IF_ACC, DM_ACC: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    if_done   = (state_q == IF_ACC) & finish & ~if_drop;
    dm_done   = (state_q == DM_ACC) & finish;
    err       = (if_done | dm_done) & (mem_done ? mem_err : 1'b1);
    if_rdata  = (if_done & mem_done) ? mem_rdata : if_rdata_q;
    dm_rdata  = (dm_done & mem_done) ? mem_rdata : dm_rdata_q;
    if_busy   = if_req & ~if_done;
    dm_busy   = (dm_rd | dm_wr) & ~dm_done;
    mem_rd    = in_acc & ~wr_q;
    mem_wr    = in_acc & wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dm_q  <= 1'b0;
      cnt_q      <= '0;
      discard_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (state_q == IDLE && (grant_dm || grant_if)) begin
        last_dm_q <= grant_dm;
        cnt_q     <= '0;
        addr_q    <= grant_dm ? dm_addr : if_addr;
        wr_q      <= grant_dm & dm_wr;
        if (grant_dm) wdata_q <= dm_wdata;
      end else if (in_acc && !mem_done) begin
        cnt_q <= cnt_q + 16'd1;
      end

      // A flushed fetch still runs to completion on the bus; only its result is dropped.
      if (state_q == IF_ACC && !finish && if_flush) discard_q <= 1'b1;
      else if (state_q != IF_ACC || finish)         discard_q <= 1'b0;

      if (if_done && mem_done) if_rdata_q <= mem_rdata;
      if (dm_done && mem_done) dm_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter; inputs change 1ns after the rising edge, outputs checked 1ns later.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_rd, dm_wr, mem_done, mem_err;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_busy, dm_done, dm_busy, err, mem_rd, mem_wr;

  int vec = 0;
  int miscmp = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_busy(if_busy),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_busy(dm_busy), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first IDLE cycle after reset with all requests low.
  task automatic do_reset();
    rst = 1'b1; if_req = 0; if_flush = 0; dm_rd = 0; dm_wr = 0;
    mem_done = 0; mem_err = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vec++; if ({mem_rd, mem_wr, if_done, dm_done, err} !== 5'b0) begin
      miscmp++; $display("FAIL reset_ctrl got %b want 00000", {mem_rd, mem_wr, if_done, dm_done, err}); end
    vec++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscmp++; $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata); end
    vec++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      miscmp++; $display("FAIL reset_rdata got if=%h dm=%h want 0/0", if_rdata, dm_rdata); end
  endtask

  task automatic test_fetch();
    int rd_cycles = 0;
    do_reset();
    if_req = 1; if_addr = 32'h100;
    #1;
    vec++; if (mem_rd !== 1'b0 || if_busy !== 1'b1) begin
      miscmp++; $display("FAIL fetch_req_cycle got mem_rd=%b busy=%b want 0/1", mem_rd, if_busy); end
    for (int k = 1; k <= 3; k++) begin
      step();
      mem_done = (k == 3); mem_rdata = (k == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (mem_rd === 1'b1) rd_cycles++;
      vec++; if (mem_addr !== 32'h100 || if_done !== (k == 3)) begin
        miscmp++; $display("FAIL fetch_acc k=%0d got addr=%h done=%b want 100/%b", k, mem_addr, if_done, k == 3); end
    end
    vec++; if (if_rdata !== 32'hDEADBEEF || err !== 1'b0 || if_busy !== 1'b0) begin
      miscmp++; $display("FAIL fetch_data got rdata=%h err=%b busy=%b want deadbeef/0/0", if_rdata, err, if_busy); end
    step();
    mem_done = 0; mem_rdata = 32'h0; if_req = 0;
    #1;
    if (mem_rd === 1'b1) rd_cycles++;
    vec++; if (rd_cycles != 3) begin
      miscmp++; $display("FAIL fetch_rd_len got %0d cycles want 3", rd_cycles); end
    vec++; if (if_done !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      miscmp++; $display("FAIL fetch_hold got done=%b rdata=%h want 0/deadbeef", if_done, if_rdata); end
  endtask

  task automatic test_alternate();
    logic exp_dm;
    logic [31:0] exp_addr;
    do_reset();
    if_req = 1; if_addr = 32'h400; dm_rd = 1; dm_addr = 32'h800;
    for (int a = 0; a < 4; a++) begin
      exp_dm = (a % 2 == 0);
      exp_addr = exp_dm ? 32'h800 : 32'h400;
      step();
      #1;
      vec++; if (mem_rd !== 1'b1 || mem_addr !== exp_addr || (if_done | dm_done) !== 1'b0) begin
        miscmp++; $display("FAIL alt%0d_acc got rd=%b addr=%h want 1/%h", a, mem_rd, mem_addr, exp_addr); end
      step();
      mem_done = 1; mem_rdata = 32'hA000 + a;
      #1;
      vec++; if (mem_addr !== exp_addr || dm_done !== exp_dm || if_done !== !exp_dm) begin
        miscmp++; $display("FAIL alt%0d_done got addr=%h dm=%b if=%b want %h/%b/%b", a, mem_addr, dm_done, if_done, exp_addr, exp_dm, !exp_dm); end
      step();
      mem_done = 0;
      if (a == 3) begin if_req = 0; dm_rd = 0; end
      #1;
      vec++; if (mem_rd !== 1'b0 || (exp_dm ? dm_rdata : if_rdata) !== 32'hA000 + a) begin
        miscmp++; $display("FAIL alt%0d_idle got rd=%b rdata=%h want 0/%h", a, mem_rd, exp_dm ? dm_rdata : if_rdata, 32'hA000 + a); end
    end
  endtask

  // tie=0: memory never answers; tie=1: mem_done lands exactly on the terminal-count cycle.
  task automatic test_timeout(input bit tie);
    int done_at = -1;
    logic err_at = 1'b0;
    logic [31:0] rdata_at = 32'h0;
    bit stable = 1'b1;
    do_reset();
    dm_wr = 1; dm_addr = 32'h20; dm_wdata = 32'h55;
    for (int k = 1; k <= 255; k++) begin
      step();
      mem_done = tie && (k == 255); mem_rdata = 32'h600D;
      #1;
      if (mem_wr !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h55) stable = 1'b0;
      if (dm_done === 1'b1 && done_at < 0) begin done_at = k; err_at = err; rdata_at = dm_rdata; end
    end
    vec++; if (!stable) begin
      miscmp++; $display("FAIL tmo%0d_stable got unstable mem_wr/addr/wdata want stable 1/20/55", tie); end
    vec++; if (done_at != 255 || err_at !== !tie) begin
      miscmp++; $display("FAIL tmo%0d_done got cycle=%0d err=%b want 255/%b", tie, done_at, err_at, !tie); end
    vec++; if (rdata_at !== (tie ? 32'h600D : 32'h0)) begin
      miscmp++; $display("FAIL tmo%0d_rdata got %h want %h", tie, rdata_at, tie ? 32'h600D : 32'h0); end
    step();
    mem_done = 0; dm_wr = 0;
    #1;
    vec++; if (mem_wr !== 1'b0 || dm_done !== 1'b0) begin
      miscmp++; $display("FAIL tmo%0d_after got mem_wr=%b done=%b want 0/0", tie, mem_wr, dm_done); end
  endtask

  task automatic test_flush();
    do_reset();
    if_req = 1; if_addr = 32'h300; if_flush = 1;
    step();
    if_flush = 0;
    #1;
    vec++; if (mem_rd !== 1'b0) begin
      miscmp++; $display("FAIL flush_idle got mem_rd=%b want 0", mem_rd); end
    step();
    #1;
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 32'h300) begin
      miscmp++; $display("FAIL flush_grant got rd=%b addr=%h want 1/300", mem_rd, mem_addr); end
    step();
    if_flush = 1; dm_rd = 1; dm_addr = 32'h44;
    #1;
    step();
    if_flush = 0; if_req = 0; mem_done = 1; mem_err = 1; mem_rdata = 32'h1234;
    #1;
    vec++; if (if_done !== 1'b0 || err !== 1'b0 || mem_rd !== 1'b1 || if_rdata !== 32'h0) begin
      miscmp++; $display("FAIL flush_done got done=%b err=%b rd=%b rdata=%h want 0/0/1/0", if_done, err, mem_rd, if_rdata); end
    step();
    mem_done = 0; mem_err = 0;
    #1;
    vec++; if (mem_rd !== 1'b0 || dm_busy !== 1'b1) begin
      miscmp++; $display("FAIL flush_idle2 got rd=%b dm_busy=%b want 0/1", mem_rd, dm_busy); end
    step();
    #1;
    vec++; if (mem_rd !== 1'b1 || mem_addr !== 32'h44) begin
      miscmp++; $display("FAIL flush_dm_grant got rd=%b addr=%h want 1/44", mem_rd, mem_addr); end
    step();
    mem_done = 1; mem_err = 1; mem_rdata = 32'hCAFE;
    #1;
    vec++; if (dm_done !== 1'b1 || err !== 1'b1 || dm_rdata !== 32'hCAFE) begin
      miscmp++; $display("FAIL flush_dm_done got done=%b err=%b rdata=%h want 1/1/cafe", dm_done, err, dm_rdata); end
    step();
    mem_done = 0; mem_err = 0; dm_rd = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dm_wr = 1; dm_addr = 32'h60; dm_wdata = 32'h77;
    step();
    #1;
    vec++; if (mem_wr !== 1'b1 || mem_addr !== 32'h60) begin
      miscmp++; $display("FAIL rstmid_acc got wr=%b addr=%h want 1/60", mem_wr, mem_addr); end
    step();
    rst = 1;
    step();
    rst = 0; dm_wr = 0;
    #1;
    vec++; if (mem_wr !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      miscmp++; $display("FAIL rstmid_clear got wr=%b addr=%h wdata=%h want 0/0/0", mem_wr, mem_addr, mem_wdata); end
    step();
    mem_done = 1; mem_err = 1;
    #1;
    vec++; if ({dm_done, if_done, err} !== 3'b000) begin
      miscmp++; $display("FAIL rstmid_stray got %b want 000", {dm_done, if_done, err}); end
    step();
    mem_done = 0; mem_err = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_alternate();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule
